// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM); grant->mem_req 1 cycle, response after L, one op outstanding.
// Requesters hold req until gnt (grants only in IDLE); define ARB_PERF_CNT_EN to build the perf_conflict_o counter.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            dm_req_i,
  input  logic            dm_we_i,
  input  logic [AW-1:0]   dm_addr_i,
  input  logic [DW-1:0]   dm_wdata_i,
  input  logic [DW/8-1:0] dm_strb_i,
  output logic            dm_gnt_o,
  output logic            dm_rvalid_o,
  output logic [DW-1:0]   dm_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_strb_o,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic [31:0]     perf_conflict_o
);

  localparam int BW = DW / 8;
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] strb;
  } mem_cmd_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          flush_pend_q, flush_pend_d;

  logic          if_gnt, dm_gnt;
  logic          if_rvalid, dm_rvalid;
  logic          starve_hit;
  logic          busy;

  assign starve_hit = (STARVE_MAX != 0) && (starve_cnt_q == SW'(STARVE_MAX));
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cmd_d        = cmd_q;
    starve_cnt_d = starve_cnt_q;
    flush_pend_d = flush_pend_q;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    dm_rvalid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // DM has priority unless IF has lost STARVE_MAX times in a row
        if (if_req_i && !if_flush_i && (!dm_req_i || starve_hit)) begin
          if_gnt = 1'b1;
        end else if (dm_req_i) begin
          dm_gnt = 1'b1;
        end

        if (if_gnt) begin
          owner_d      = OWN_IF;
          cmd_d        = '{we: 1'b0, addr: if_addr_i, wdata: '0, strb: '0};
          starve_cnt_d = '0;
          flush_pend_d = 1'b0;
          state_d      = ST_REQ;
        end else if (dm_gnt) begin
          owner_d = OWN_DM;
          cmd_d   = '{we: dm_we_i, addr: dm_addr_i, wdata: dm_wdata_i, strb: dm_strb_i};
          if (if_req_i && (starve_cnt_q != SW'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if ((owner_q == OWN_IF) && if_flush_i) begin
          flush_pend_d = 1'b1;
        end
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if ((owner_q == OWN_IF) && if_flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          if (owner_q == OWN_DM) begin
            dm_rvalid = 1'b1;
          end else begin
            if_rvalid = !(flush_pend_q || if_flush_i);
          end
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      cmd_q        <= '0;
      starve_cnt_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cmd_q        <= cmd_d;
      starve_cnt_q <= starve_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Reset masks grants and responses so nothing is accepted or forwarded in that cycle
  assign if_gnt_o    = if_gnt & ~reset;
  assign dm_gnt_o    = dm_gnt & ~reset;
  assign if_rvalid_o = if_rvalid & ~reset;
  assign dm_rvalid_o = dm_rvalid & ~reset;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = busy & cmd_q.we;
  assign mem_addr_o  = busy ? cmd_q.addr : '0;
  assign mem_wdata_o = busy ? cmd_q.wdata : '0;
  assign mem_strb_o  = busy ? cmd_q.strb : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    if ((state_q == ST_IDLE) && if_req_i && dm_req_i) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_q <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
`else
  assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps plus random traffic, checked each cycle against a
// transaction-level model (busy flag, request cycle number, starvation count) and a latency-L memory.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 2;

  logic            clk, reset;
  logic            if_req_i, if_flush_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o, if_rvalid_o;
  logic [DW-1:0]   if_rdata_o;
  logic            dm_req_i, dm_we_i;
  logic [AW-1:0]   dm_addr_i;
  logic [DW-1:0]   dm_wdata_i;
  logic [DW/8-1:0] dm_strb_i;
  logic            dm_gnt_o, dm_rvalid_o;
  logic [DW-1:0]   dm_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_strb_o;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;
  logic [31:0]     perf_conflict_o;
  logic            rv_resp, rv_force;

  assign mem_rvalid_i = rv_resp | rv_force;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_strb_i(dm_strb_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .perf_conflict_o(perf_conflict_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total, bad;

  // reference model state
  int unsigned cyc, m_req_cyc;
  bit          m_busy, m_dm, m_squash, m_we;
  logic [31:0] m_addr, m_wdata, m_perf;
  logic [3:0]  m_strb;
  int          m_starve;

  // memory responder state
  bit          r_pend, r_we;
  int          r_cnt, lat_fix;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] mem [logic [31:0]];

  // outputs sampled at the falling edge of the most recent step
  logic        s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mreq, s_mwe;
  logic [31:0] s_if_rd, s_dm_rd, s_maddr, s_mwd, s_perf;
  logic [3:0]  s_mstrb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit e_ig, e_dg, e_irv, e_drv, e_mreq, force_if;
    logic [31:0] cur;
    @(negedge clk);
    s_if_gnt = if_gnt_o;  s_dm_gnt = dm_gnt_o;
    s_if_rv  = if_rvalid_o; s_if_rd = if_rdata_o;
    s_dm_rv  = dm_rvalid_o; s_dm_rd = dm_rdata_o;
    s_mreq   = mem_req_o; s_mwe = mem_we_o; s_maddr = mem_addr_o;
    s_mwd    = mem_wdata_o; s_mstrb = mem_strb_o; s_perf = perf_conflict_o;

    e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_mreq = 0; force_if = 0;
    if (!reset) begin
      if (!m_busy) begin
        force_if = (SM != 0) && (m_starve == SM);
        if (if_req_i && !if_flush_i && (!dm_req_i || force_if)) e_ig = 1;
        else if (dm_req_i) e_dg = 1;
      end else begin
        e_mreq = (cyc == m_req_cyc);
        if (cyc > m_req_cyc && mem_rvalid_i) begin
          if (m_dm) e_drv = 1;
          else e_irv = !m_squash;
        end
      end
    end
    chk("grant", 64'({s_if_gnt, s_dm_gnt}), 64'({e_ig, e_dg}));
    chk("if_resp", 64'({s_if_rv, s_if_rd}), 64'({e_irv, e_irv ? mem_rdata_i : 32'h0}));
    chk("dm_resp", 64'({s_dm_rv, s_dm_rd}), 64'({e_drv, e_drv ? mem_rdata_i : 32'h0}));
    chk("mem_req", 64'(s_mreq), 64'(e_mreq));
    if (m_busy && cyc >= m_req_cyc) begin
      chk("mem_cmd", 64'({s_mwe, s_maddr}), 64'({m_we, m_addr}));
      if (m_we) chk("mem_wr", 64'({s_mwd, s_mstrb}), 64'({m_wdata, m_strb}));
    end
`ifdef ARB_PERF_CNT_EN
    chk("perf", 64'(s_perf), 64'(m_perf));
`else
    chk("perf", 64'(s_perf), 64'(0));
`endif

    if (s_mreq) begin
      r_pend = 1; r_cnt = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
      r_we = s_mwe; r_addr = s_maddr; r_wdata = s_mwd; r_strb = s_mstrb;
    end

    if (reset) begin
      m_busy = 0; m_starve = 0; m_squash = 0; m_perf = 0;
    end else begin
      if (!m_busy && if_req_i && dm_req_i) m_perf = m_perf + 32'd1;
      if (e_ig) begin
        m_busy = 1; m_dm = 0; m_req_cyc = cyc + 1; m_we = 0; m_addr = if_addr_i;
        m_starve = 0; m_squash = 0;
      end else if (e_dg) begin
        m_busy = 1; m_dm = 1; m_req_cyc = cyc + 1; m_we = dm_we_i; m_addr = dm_addr_i;
        m_wdata = dm_wdata_i; m_strb = dm_strb_i;
        if (if_req_i && m_starve < SM) m_starve++;
      end else if (m_busy) begin
        if (!m_dm && if_flush_i) m_squash = 1;
        if (cyc > m_req_cyc && mem_rvalid_i) begin
          m_busy = 0; m_squash = 0;
        end
      end
    end
    cyc++;

    @(posedge clk);
    #1;
    rv_resp = 0;
    if (r_pend) begin
      r_cnt--;
      if (r_cnt == 0) begin
        r_pend = 0; rv_resp = 1;
        if (r_we) begin
          cur = mem.exists(r_addr) ? mem[r_addr] : 32'h0;
          for (int b = 0; b < 4; b++) if (r_strb[b]) cur[8*b +: 8] = r_wdata[8*b +: 8];
          mem[r_addr] = cur;
          mem_rdata_i = $urandom;
        end else begin
          mem_rdata_i = mem.exists(r_addr) ? mem[r_addr] : 32'h0;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    if_req_i = 0; dm_req_i = 0; if_flush_i = 0; rv_force = 0;
    while ((m_busy || r_pend) && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) chk("drain_timeout", 64'(m_busy), 64'(0));
  endtask

  int   ng, p0;
  int   order [6];
  int   exp_order [6];

  initial begin
    total = 0; bad = 0; cyc = 0;
    m_busy = 0; m_dm = 0; m_squash = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_strb = 0;
    m_perf = 0; m_starve = 0; m_req_cyc = 0;
    r_pend = 0; r_cnt = 0; r_we = 0; r_addr = 0; r_wdata = 0; r_strb = 0; lat_fix = 2;
    if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = 0; dm_wdata_i = 0; dm_strb_i = 0;
    rv_resp = 0; rv_force = 0; mem_rdata_i = 0;
    exp_order = '{1, 1, 0, 1, 1, 0};
    order = '{default: 9};
    reset = 1;
    @(posedge clk);
    #1;
    step(); step();
    reset = 0;
    step();
    chk("rst_ctl", 64'({s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mreq, s_mwe, s_mstrb}), 64'(0));
    chk("rst_addr", 64'(s_maddr), 64'(0));
    chk("rst_wdata", 64'(s_mwd), 64'(0));
    chk("rst_rdata", 64'({s_if_rd, s_dm_rd}), 64'(0));

    // lone IF read, L=2
    lat_fix = 2; mem[32'h40] = 32'hDEADBEEF;
    if_req_i = 1; if_addr_i = 32'h40;
    step(); chk("ifrd_gnt_T", 64'(s_if_gnt), 64'(1));
    if_req_i = 0;
    step(); chk("ifrd_req_T1", 64'({s_mreq, s_maddr}), 64'({1'b1, 32'h40}));
    step(); chk("ifrd_norv_T2", 64'(s_if_rv), 64'(0));
    step(); chk("ifrd_rv_T3", 64'({s_if_rv, s_if_rd}), 64'({1'b1, 32'hDEADBEEF}));
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h44;
    step(); chk("ifrd_idle_T4", 64'(s_dm_gnt), 64'(1));
    drain();

    // starvation: both held, L=1
    lat_fix = 1; ng = 0;
    if_req_i = 1; if_addr_i = 32'h200; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h300;
    for (int i = 0; i < 60 && ng < 6; i++) begin
      step();
      if (s_if_gnt && ng < 6) begin order[ng] = 0; ng++; if_addr_i += 4; end
      if (s_dm_gnt && ng < 6) begin order[ng] = 1; ng++; dm_addr_i += 4; end
    end
    chk("starve_ngrants", 64'(ng), 64'(6));
    for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), 64'(order[i]), 64'(exp_order[i]));
    drain();

    // DM write, L=2
    lat_fix = 2;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h100; dm_wdata_i = 32'h12345678; dm_strb_i = 4'hF;
    step(); chk("wr_gnt", 64'(s_dm_gnt), 64'(1));
    dm_req_i = 0;
    step(); chk("wr_req", 64'({s_mreq, s_mwe, s_mstrb, s_maddr, s_mwd}), 64'({1'b1, 1'b1, 4'hF, 32'h100, 32'h12345678}) & 64'h3F_FFFF_FFFF_FFFF);
    step(); chk("wr_wait", 64'({s_mreq, s_mwe, s_mstrb}), 64'({1'b0, 1'b1, 4'hF}));
    step(); chk("wr_ack", 64'({s_dm_rv, s_if_rv}), 64'({1'b1, 1'b0}));
    drain();

    // IF read flushed in WAIT, L=3
    lat_fix = 3;
    if_req_i = 1; if_addr_i = 32'h80;
    step(); chk("fl_gnt", 64'(s_if_gnt), 64'(1));
    if_req_i = 0;
    step();
    if_flush_i = 1;
    step();
    if_flush_i = 0; if_req_i = 1; if_addr_i = 32'h84;
    step(); chk("fl_busy_nognt", 64'(s_if_gnt), 64'(0));
    step(); chk("fl_dropped", 64'({s_if_rv, s_dm_rv, s_if_rd}), 64'(0));
    step(); chk("fl_next_gnt", 64'(s_if_gnt), 64'(1));
    drain();

    // reset during WAIT, late response must be ignored
    lat_fix = 3;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h40;
    step(); chk("rw_gnt", 64'(s_dm_gnt), 64'(1));
    dm_req_i = 0;
    step(); step();
    reset = 1;
    step();
    reset = 0;
    step();
    chk("rw_ctl", 64'({s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv, s_mreq, s_mwe, s_mstrb}), 64'(0));
    chk("rw_data", 64'({s_if_rd, s_dm_rd}), 64'(0));
    chk("rw_addr", 64'({s_maddr, s_mwd}), 64'(0));
    dm_req_i = 1;
    step(); chk("rw_regnt", 64'(s_dm_gnt), 64'(1));
    drain();

    // mem_rvalid_i in IDLE and in REQ is ignored
    rv_force = 1;
    step(); chk("idle_rv_ign", 64'({s_if_rv, s_dm_rv, s_mreq}), 64'(0));
    rv_force = 0; lat_fix = 2;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h100;
    step();
    dm_req_i = 0; rv_force = 1;
    step(); chk("req_rv_ign", 64'({s_mreq, s_dm_rv}), 64'({1'b1, 1'b0}));
    rv_force = 0;
    step();
    step(); chk("req_rv_real", 64'({s_dm_rv, s_dm_rd}), 64'({1'b1, 32'h12345678}));
    drain();

    // conflict counter: both held for 10 cycles, L=1
    lat_fix = 1;
    if_req_i = 1; if_addr_i = 32'h40; dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h44;
    step(); p0 = int'(s_perf);
    for (int i = 0; i < 9; i++) step();
    if_req_i = 0; dm_req_i = 0;
    step();
`ifdef ARB_PERF_CNT_EN
    chk("perf_delta", 64'(s_perf - 32'(p0)), 64'(4));
`else
    chk("perf_zero", 64'({s_perf, 32'(p0)}), 64'(0));
`endif
    drain();

    // random traffic
    lat_fix = 0;
    for (int i = 0; i < 800; i++) begin
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dm_req_i && $urandom_range(0, 2) == 0) begin
        dm_req_i = 1; dm_we_i = 1'($urandom_range(0, 1));
        dm_addr_i = 32'($urandom_range(0, 63)) << 2;
        dm_wdata_i = $urandom; dm_strb_i = 4'($urandom_range(1, 15));
      end
      if_flush_i = !(rv_resp | rv_force) && ($urandom_range(0, 9) == 0);
      step();
      if (s_if_gnt) if_req_i = 0;
      if (s_dm_gnt) dm_req_i = 0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
